// File: rtl/clk_wiz_supervisor.sv
// Reset/lock supervisor for the clock wizard, clocked only by the free-running 100 MHz input.
// Optional lock-loss event counter enabled by macro CLK_WIZ_LOSS_CNT_EN.
module clk_wiz_supervisor #(
  parameter int RST_PULSE_CYC    = 10,
  parameter int LOCK_TIMEOUT_CYC = 100000,
  parameter int STABLE_CYC       = 64,
  parameter int MAX_RETRY        = 3
) (
  input  logic        clk_100M,
  input  logic        reset_n,
  input  logic        locked,
  output logic        clk_wiz_reset,
  output logic        sys_rst_n,
  output logic        lock_ok,
  output logic        fault,
  output logic [3:0]  retry_cnt
`ifdef CLK_WIZ_LOSS_CNT_EN
  ,
  output logic [15:0] loss_cnt
`endif
);

  localparam int MAX_A = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_P = (MAX_A > STABLE_CYC) ? MAX_A : STABLE_CYC;
  localparam int CW    = $clog2(MAX_P + 1);

  // The WAIT_LOCK cycle that first sees locked_s high counts as the first stable cycle.
  localparam int STABLE_END = (STABLE_CYC > 1) ? STABLE_CYC - 2 : 0;

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_END);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRY);

  // RST_PULSE: wizard held in reset | WAIT_LOCK: await lock | STABLE: qualify lock | RUN: released | FAULT: sticky
  typedef enum logic [2:0] {
    S_RST_PULSE,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_sync1;
  logic            r_sync2;
  logic            w_locked_s;
  logic            w_retry_inc;
  logic            w_retry_clr;
  logic [3:0]      r_retry;
  logic            r_clk_wiz_reset;
  logic            r_sys_rst_n;
  logic            r_lock_ok;
  logic            r_fault;

  assign w_locked_s = r_sync2;

  always_comb begin
    w_state_nxt = r_state;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    case (r_state)
      S_RST_PULSE: begin
        if (r_cnt == PULSE_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          if (r_retry == RETRY_MAX) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_state_nxt = S_RST_PULSE;
            w_retry_inc = 1'b1;
          end
        end
      end
      S_STABLE: begin
        if (!w_locked_s) w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = S_RST_PULSE;
          w_retry_clr = 1'b1;
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_RST_PULSE;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (!reset_n) begin
      r_state         <= S_RST_PULSE;
      r_cnt           <= '0;
      r_sync1         <= 1'b0;
      r_sync2         <= 1'b0;
      r_retry         <= 4'd0;
      r_clk_wiz_reset <= 1'b1;
      r_sys_rst_n     <= 1'b0;
      r_lock_ok       <= 1'b0;
      r_fault         <= 1'b0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 1'b1;
      if (w_retry_clr)      r_retry <= 4'd0;
      else if (w_retry_inc) r_retry <= r_retry + 4'd1;
      // Outputs decode the next state so they change on the same edge as the state.
      r_clk_wiz_reset <= (w_state_nxt == S_RST_PULSE) || (w_state_nxt == S_FAULT);
      r_sys_rst_n     <= (w_state_nxt == S_RUN);
      r_lock_ok       <= (w_state_nxt == S_RUN);
      r_fault         <= (w_state_nxt == S_FAULT);
    end
  end

  assign clk_wiz_reset = r_clk_wiz_reset;
  assign sys_rst_n     = r_sys_rst_n;
  assign lock_ok       = r_lock_ok;
  assign fault         = r_fault;
  assign retry_cnt     = r_retry;

`ifdef CLK_WIZ_LOSS_CNT_EN
  logic        w_loss;
  logic [15:0] r_loss_cnt;

  assign w_loss = (r_state == S_RUN) && !w_locked_s;

  always_ff @(posedge clk_100M) begin
    if (!reset_n)                              r_loss_cnt <= 16'd0;
    else if (w_loss && r_loss_cnt != 16'hFFFF) r_loss_cnt <= r_loss_cnt + 16'd1;
  end

  assign loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_clk_wiz_supervisor.sv
// Scoreboard bench for clk_wiz_supervisor: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_clk_wiz_supervisor;

  localparam int RP = 4;
  localparam int TO = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  logic       clk_100M = 1'b0;
  logic       reset_n  = 1'b0;
  logic       locked   = 1'b0;
  logic       clk_wiz_reset;
  logic       sys_rst_n;
  logic       lock_ok;
  logic       fault;
  logic [3:0] retry_cnt;
`ifdef CLK_WIZ_LOSS_CNT_EN
  logic [15:0] loss_cnt;
`endif

  clk_wiz_supervisor #(
    .RST_PULSE_CYC(RP),
    .LOCK_TIMEOUT_CYC(TO),
    .STABLE_CYC(SC),
    .MAX_RETRY(MR)
  ) dut (
    .clk_100M(clk_100M),
    .reset_n(reset_n),
    .locked(locked),
    .clk_wiz_reset(clk_wiz_reset),
    .sys_rst_n(sys_rst_n),
    .lock_ok(lock_ok),
    .fault(fault),
    .retry_cnt(retry_cnt)
`ifdef CLK_WIZ_LOSS_CNT_EN
    ,
    .loss_cnt(loss_cnt)
`endif
  );

  always #5 clk_100M = ~clk_100M;

  int cyc = 0;
  always @(posedge clk_100M) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
    int         loss;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // {clk_wiz_reset, sys_rst_n, lock_ok, fault, retry_cnt}
  function automatic logic [7:0] ov(bit cwr, bit srn, bit lok, bit flt, int rc);
    return {cwr, srn, lok, flt, 4'(rc)};
  endfunction

  always @(negedge clk_100M) begin : monitor
    exp_t       e;
    logic [7:0] got;
    got = {clk_wiz_reset, sys_rst_n, lock_ok, fault, retry_cnt};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
      end else if (got !== e.vec) begin
        errors++;
        $display("FAIL %s @cyc %0d: got {cwr,srn,lok,flt,rc}=%b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
                 e.name, cyc, got[7], got[6], got[5], got[4], got[3:0],
                 e.vec[7], e.vec[6], e.vec[5], e.vec[4], e.vec[3:0]);
      end
`ifdef CLK_WIZ_LOSS_CNT_EN
      if (e.loss >= 0) begin
        checks++;
        if (loss_cnt !== 16'(e.loss)) begin
          errors++;
          $display("FAIL %s loss_cnt @cyc %0d: got %0d required %0d", e.name, cyc, loss_cnt, e.loss);
        end
      end
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_100M);
      #1;
    end
  endtask

  task automatic exp_rng(input string nm, input int a, input int b, input logic [7:0] v);
    for (int c = a; c <= b; c++) sb.push_back('{c, v, -1, nm});
  endtask

  task automatic exp_loss(input string nm, input int c, input logic [7:0] v, input int loss);
    sb.push_back('{c, v, loss, nm});
  endtask

  task automatic do_reset(output int t0);
    locked  = 1'b0;
    reset_n = 1'b0;
    step(2);
    t0      = cyc;
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int t0;
    int f;
    int t1;
    int t2;
    logic [7:0] v_rp0, v_rp1, v_rp2, v_wl0, v_wl1, v_wl2, v_run, v_flt;
    v_rp0 = ov(1, 0, 0, 0, 0);
    v_rp1 = ov(1, 0, 0, 0, 1);
    v_rp2 = ov(1, 0, 0, 0, 2);
    v_wl0 = ov(0, 0, 0, 0, 0);
    v_wl1 = ov(0, 0, 0, 0, 1);
    v_wl2 = ov(0, 0, 0, 0, 2);
    v_run = ov(0, 1, 1, 0, 0);
    v_flt = ov(1, 0, 0, 1, 2);

    // Clean lock: locked rises 5 cycles after clk_wiz_reset falls.
    do_reset(t0);
    exp_loss("reset_state", t0, v_rp0, 0);
    exp_rng("clean_pulse", t0 + 1, t0 + 3, v_rp0);
    exp_rng("clean_wait", t0 + 4, t0 + 18, v_wl0);
    exp_rng("clean_run", t0 + 19, t0 + 21, v_run);
    step(9);
    locked = 1'b1;
    step(12);

    // Lock loss in RUN, then relock.
    f = cyc;
    exp_rng("loss_run_hold", f + 1, f + 2, v_run);
    exp_rng("loss_pulse", f + 3, f + 6, v_rp0);
    exp_rng("loss_wait", f + 7, f + 19, v_wl0);
    exp_rng("loss_relock", f + 20, f + 21, v_run);
    exp_loss("loss_count", f + 22, v_run, 1);
    locked = 1'b0;
    step(10);
    locked = 1'b1;
    step(12);

    // One-cycle glitch 5 cycles after first lock.
    do_reset(t0);
    exp_loss("glitch_reset", t0, v_rp0, 0);
    exp_rng("glitch_pulse", t0 + 1, t0 + 3, v_rp0);
    exp_rng("glitch_qualify", t0 + 4, t0 + 24, v_wl0);
    exp_rng("glitch_run", t0 + 25, t0 + 26, v_run);
    step(9);
    locked = 1'b1;
    step(5);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(12);

    // No lock: three attempts, then FAULT; reset_n clears FAULT.
    do_reset(t0);
    exp_rng("nolock_pulse0", t0, t0 + 3, v_rp0);
    exp_rng("nolock_gap0", t0 + 4, t0 + 23, v_wl0);
    exp_rng("nolock_pulse1", t0 + 24, t0 + 27, v_rp1);
    exp_rng("nolock_gap1", t0 + 28, t0 + 47, v_wl1);
    exp_rng("nolock_pulse2", t0 + 48, t0 + 51, v_rp2);
    exp_rng("nolock_gap2", t0 + 52, t0 + 71, v_wl2);
    exp_rng("nolock_fault", t0 + 72, t0 + 76, v_flt);
    step(76);
    reset_n = 1'b0;
    step(1);
    exp_loss("fault_reset", cyc, v_rp0, 0);
    reset_n = 1'b1;
    t1 = cyc;

    // Reset during WAIT_LOCK with retry_cnt=1.
    exp_rng("wreset_pulse0", t1 + 1, t1 + 3, v_rp0);
    exp_rng("wreset_gap0", t1 + 4, t1 + 23, v_wl0);
    exp_rng("wreset_pulse1", t1 + 24, t1 + 27, v_rp1);
    exp_rng("wreset_wait1", t1 + 28, t1 + 30, v_wl1);
    step(30);
    reset_n = 1'b0;
    step(1);
    exp_loss("wait_reset", cyc, v_rp0, 0);
    reset_n = 1'b1;
    t2 = cyc;

    // Late lock: locked_s first high in WAIT_LOCK counter cycle 19.
    exp_rng("late_pulse", t2 + 1, t2 + 3, v_rp0);
    exp_rng("late_wait", t2 + 4, t2 + 30, v_wl0);
    exp_rng("late_run", t2 + 31, t2 + 32, v_run);
    step(21);
    locked = 1'b1;
    step(11);

    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
